hilo_muldiv: RTL

- Parametrised HI/LO register unit with an integrated multiply/divide engine for the CPU execute stage.
- Executes MULT/MULTU (2-cycle) and DIV/DIVU (iterative, DATA_W+2 cycles) and writes HI/LO directly.
- Handles MTHI/MTLO writes independently, with a ready/valid issue handshake and a flush input for exceptions.
- Replaces the plain single-enable HI/LO register.

---
 rtl/hilo_pkg.sv | 19 +
 rtl/div_iter_unsigned.sv | 59 +++++
 rtl/hilo_muldiv.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared op codes and FSM state encoding for the HI/LO mul/div unit.
package hilo_pkg;

  localparam int unsigned OP_NOP   = 0;
  localparam int unsigned OP_MULT  = 1;
  localparam int unsigned OP_MULTU = 2;
  localparam int unsigned OP_DIV   = 3;
  localparam int unsigned OP_DIVU  = 4;
  localparam int unsigned OP_MTHI  = 5;
  localparam int unsigned OP_MTLO  = 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_e;

endpackage

// File: rtl/div_iter_unsigned.sv
// Unsigned restoring divider core: start loads operands, each step retires one quotient bit.
module div_iter_unsigned #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dsr_q, dsr_d;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;

  // Quotient register doubles as the dividend shift register.
  always_comb begin
    shifted = {rem_q, quo_q[DATA_W-1]};
    trial   = shifted - {1'b0, dsr_q};
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dsr_d = divisor;
    end else if (step) begin
      // Top bit of the trial set means the subtract went negative: restore.
      if (trial[DATA_W]) begin
        rem_d = shifted[DATA_W-1:0];
        quo_d = {quo_q[DATA_W-2:0], 1'b0};
      end else begin
        rem_d = trial[DATA_W-1:0];
        quo_d = {quo_q[DATA_W-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dsr_q <= dsr_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv.sv
// Architectural HI/LO registers with a 2-cycle multiplier and iterative divider.
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [OP_W-1:0]   op_code,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic              mul_sgn_q, mul_sgn_d;
  logic              q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic              dz_q, dz_d;
  logic [DATA_W-1:0] dz_a_q, dz_a_d;

  logic                accept;
  logic                is_div, is_sdiv, a_neg, b_neg;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [2*DATA_W-1:0] mul_a_ext, mul_b_ext, prod;
  logic [DATA_W-1:0]   quo, rem;
  logic                div_start, div_step;

  assign op_ready = (state_q == S_IDLE);
  assign busy     = !op_ready;
  assign done     = done_q;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;

  assign accept  = op_valid && op_ready && !flush;
  assign is_sdiv = (op_code == OP_W'(OP_DIV));
  assign is_div  = is_sdiv || (op_code == OP_W'(OP_DIVU));
  assign a_neg   = is_sdiv && src_a[DATA_W-1];
  assign b_neg   = is_sdiv && src_b[DATA_W-1];
  // Negating MIN wraps back to MIN, which is the correct unsigned magnitude.
  assign abs_a   = a_neg ? -src_a : src_a;
  assign abs_b   = b_neg ? -src_b : src_b;

  // Sign-extend to full product width so one unsigned multiply serves both flavours.
  assign mul_a_ext = {{DATA_W{mul_sgn_q & mul_a_q[DATA_W-1]}}, mul_a_q};
  assign mul_b_ext = {{DATA_W{mul_sgn_q & mul_b_q[DATA_W-1]}}, mul_b_q};
  assign prod      = mul_a_ext * mul_b_ext;

  assign div_start = accept && is_div;
  assign div_step  = (state_q == S_DIV) && !flush;

  div_iter_unsigned #(
    .DATA_W (DATA_W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .step      (div_step),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (quo),
    .remainder (rem)
  );

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_sgn_d = mul_sgn_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    dz_d      = dz_q;
    dz_a_d    = dz_a_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_code)
            OP_W'(OP_MULT), OP_W'(OP_MULTU): begin
              mul_a_d   = src_a;
              mul_b_d   = src_b;
              mul_sgn_d = (op_code == OP_W'(OP_MULT));
              state_d   = S_MUL;
            end
            OP_W'(OP_DIV), OP_W'(OP_DIVU): begin
              q_neg_d = a_neg ^ b_neg;
              r_neg_d = a_neg;
              dz_d    = (src_b == '0);
              dz_a_d  = src_a;
              cnt_d   = CntW'(DATA_W);
              state_d = S_DIV;
            end
            OP_W'(OP_MTHI): hi_d = src_a;
            OP_W'(OP_MTLO): lo_d = src_a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        state_d = S_IDLE;
        if (!flush) begin
          {hi_d, lo_d} = prod;
          done_d       = 1'b1;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (dz_q) begin
            lo_d = '1;
            hi_d = dz_a_q;
          end else begin
            lo_d = q_neg_q ? -quo : quo;
            hi_d = r_neg_q ? -rem : rem;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_sgn_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dz_q      <= 1'b0;
      dz_a_q    <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      mul_sgn_q <= mul_sgn_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      dz_q      <= dz_d;
      dz_a_q    <= dz_a_d;
    end
  end

endmodule
